maxpool_ctrl: RTL

Sequencer for one max-pooling pass over a single feature map held in on-chip RAM. On `start` it walks every pooling window in row-major order, issues the window's reads to the input feature-map RAM, tracks the signed maximum, and writes one result per window to the output RAM. It sits between the layer scheduler (`start`/`done`) and the feature-map buffers, and replaces ad-hoc address counting for the pooling stage.

---
 rtl/maxpool_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/maxpool_ctrl.sv
// Max-pooling sequencer: walks every pooling window of one feature map in RAM,
// reads each window's samples, keeps the signed maximum and writes one result per window.
module maxpool_ctrl #(
    parameter int DATAI_WIDTH  = 4,
    parameter int DATAI_HEIGHT = 4,
    parameter int KERNEL       = 2,
    parameter int STRIDE       = 1,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8
) (
    input  logic              clk_en,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int DATAO_WIDTH  = (DATAI_WIDTH - KERNEL) / STRIDE + 1;
    localparam int DATAO_HEIGHT = (DATAI_HEIGHT - KERNEL) / STRIDE + 1;

    localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(KERNEL - 1);
    localparam logic [ADDR_W-1:0] OW_LAST = ADDR_W'(DATAO_WIDTH - 1);
    localparam logic [ADDR_W-1:0] OH_LAST = ADDR_W'(DATAO_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] IW      = ADDR_W'(DATAI_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ki_q, ki_d, kj_q, kj_d;
    logic [ADDR_W-1:0] arow_q, arow_d, acol_q, acol_d;
    logic [ADDR_W-1:0] orow_q, orow_d, ocol_q, ocol_d;
    logic [ADDR_W-1:0] oidx_q, oidx_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              smp_valid_q, smp_valid_d;
    logic              smp_first_q, smp_first_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // A sample returns one cycle after its read; the first read of a window
    // restarts the maximum so nothing carries over from the previous window.
    always_comb begin
        max_d = max_q;
        if (smp_valid_q) begin
            if (smp_first_q || ($signed(rd_data) > $signed(max_q))) begin
                max_d = rd_data;
            end
        end
    end

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d     = state_q;
        ki_d        = ki_q;
        kj_d        = kj_q;
        arow_d      = arow_q;
        acol_d      = acol_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        oidx_d      = oidx_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        smp_valid_d = (state_q == S_FETCH);
        smp_first_d = (state_q == S_FETCH) && (ki_q == '0) && (kj_q == '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (kj_q == K_LAST) begin
                    kj_d = '0;
                    if (ki_q == K_LAST) begin
                        ki_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        ki_d = ki_q + 1'b1;
                    end
                end else begin
                    kj_d = kj_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d   = S_WRITE;
                wr_addr_d = oidx_q;
                wr_data_d = max_d;
            end
            S_WRITE: begin
                if ((ocol_q == OW_LAST) && (orow_q == OH_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    oidx_d  = oidx_q + 1'b1;
                    if (ocol_q == OW_LAST) begin
                        ocol_d = '0;
                        acol_d = '0;
                        orow_d = orow_q + 1'b1;
                        arow_d = arow_q + STEP;
                    end else begin
                        ocol_d = ocol_q + 1'b1;
                        acol_d = acol_q + STEP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                arow_d  = '0;
                acol_d  = '0;
                orow_d  = '0;
                ocol_d  = '0;
                oidx_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase

        rd_en_d = (state_d == S_FETCH);
        wr_en_d = (state_d == S_WRITE);
        busy_d  = (state_d == S_FETCH) || (state_d == S_DRAIN) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        if (rd_en_d) begin
            rd_addr_d = (arow_d + ki_d) * IW + acol_d + kj_d;
        end
    end

    always_ff @(posedge clk_en) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ki_q        <= '0;
            kj_q        <= '0;
            arow_q      <= '0;
            acol_q      <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            oidx_q      <= '0;
            max_q       <= '0;
            smp_valid_q <= 1'b0;
            smp_first_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ki_q        <= ki_d;
            kj_q        <= kj_d;
            arow_q      <= arow_d;
            acol_q      <= acol_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            oidx_q      <= oidx_d;
            max_q       <= max_d;
            smp_valid_q <= smp_valid_d;
            smp_first_q <= smp_first_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
